muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit. Consumes register-file read data (readData1/readData2)
//   and produces writeData/rd/regWrite for the register file's write port.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / divide unit (MUL, MULHU, DIVU, REMU).
// One operation is in flight at a time. The core stalls on busy, and the result
// feeds the register-file write port through result/rd_out/reg_write.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  // WB registers the selected result; DONE then presents it for one cycle.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic            r_dz;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd;

  // Datapath: r_hi is the upper accumulator (multiply) or the partial remainder (divide).
  // r_lo is the multiplier / low product (multiply) or the dividend / quotient (divide).
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;

  logic            w_accept;
  logic            w_dz_in;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_res_sel;

  // Pick the architectural result from the finished datapath.
  // Division by zero follows the RISC-V rule: the quotient is all ones and the
  // remainder is the dividend, which still sits untouched in lo.
  function automatic logic [XLEN-1:0] sel_result(
    input logic [1:0]      f_op,
    input logic            f_dz,
    input logic [XLEN-1:0] f_hi,
    input logic [XLEN-1:0] f_lo
  );
    logic [XLEN-1:0] v;
    case (f_op)
      OP_MUL:   v = f_lo;
      OP_MULHU: v = f_hi;
      OP_DIVU:  v = f_dz ? '1 : f_lo;
      OP_REMU:  v = f_dz ? f_lo : f_hi;
      default:  v = '0;
    endcase
    return v;
  endfunction

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_dz_in   = op[1] && (rs2_val == '0);
  assign w_res_sel = sel_result(r_op, r_dz, r_hi, r_lo);

  // Next-state logic: a divide by zero skips the iteration phase entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_dz_in ? S_WB : S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_state_nxt = S_WB;
      S_WB:   w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, iteration counter, latched op/rd and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_dz     <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_rd  <= rd_in;
        r_dz  <= w_dz_in;
        r_cnt <= w_dz_in ? '0 : CW'(XLEN);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_WB) r_result <= w_res_sel;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shl  = {r_hi, r_lo[XLEN-1]};
    w_diff = w_shl - {1'b0, r_b};
    w_ge   = (w_shl >= {1'b0, r_b});
    if (r_op[1]) begin
      w_hi_nxt = w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Datapath registers: loaded at accept, stepped once per RUN cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hi <= '0;
      r_lo <= rs1_val;
      r_b  <= rs2_val;
    end else if (r_state == S_RUN) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign reg_write = done && (r_rd != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: multiply/divide results, latency,
// divide-by-zero, start-while-busy, rd=x0 and reset abort.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            reg_write;

  int vectors;
  int miscompares;
  int lat;
  int extra_done;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op in the next cycle, scramble operands after accept, then
  // count cycles until done (returns -1 if done never arrives).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int latency);
    @(posedge clk); #1;
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom); op = 2'($urandom);
    latency = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        latency = i;
        break;
      end
    end
  endtask

  // Watch for any done pulse over n cycles.
  task automatic watch_no_done(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd_in = '0;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_regwrite", 32'(reg_write), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;

    // 1. MUL 7*6 -> 42, latency 33, reg_write for exactly one cycle
    run_op(2'b00, 32'd7, 32'd6, 5'd5, lat);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_res", result, 32'd42);
    check("mul_rd", 32'(rd_out), 32'd5);
    check("mul_busy_done", 32'(busy), 32'd1);
    check("mul_regwrite", 32'(reg_write), 32'd1);
    @(posedge clk); #1;
    check("mul_done_off", 32'(done), 32'd0);
    check("mul_regwrite_off", 32'(reg_write), 32'd0);
    check("mul_busy_off", 32'(busy), 32'd0);
    check("mul_res_held", result, 32'd42);

    // 2. MULHU / MUL of all-ones operands
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, lat);
    check("mulhu_lat", 32'(lat), 32'd33);
    check("mulhu_res", result, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, lat);
    check("mul_ff_res", result, 32'h0000_0001);

    // 3. DIVU / REMU 100/7, issued back to back
    run_op(2'b10, 32'd100, 32'd7, 5'd8, lat);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_res", result, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, 5'd9, lat);
    check("remu_lat", 32'(lat), 32'd33);
    check("remu_res", result, 32'd2);
    check("remu_rd", 32'(rd_out), 32'd9);
    run_op(2'b10, 32'h8000_0000, 32'd3, 5'd10, lat);
    check("divu_msb_res", result, 32'h2AAA_AAAA);
    run_op(2'b11, 32'h8000_0000, 32'd3, 5'd10, lat);
    check("remu_msb_res", result, 32'd2);

    // 4. Divide by zero
    run_op(2'b10, 32'h0000_1234, 32'd0, 5'd11, lat);
    check("divz_lat", 32'(lat), 32'd1);
    check("divz_res", result, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h0000_1234, 32'd0, 5'd12, lat);
    check("remz_lat", 32'(lat), 32'd1);
    check("remz_res", result, 32'h0000_1234);
    check("remz_rd", 32'(rd_out), 32'd12);

    // 5. start pulses while busy (cycles 3 and 10, and in the DONE cycle) are ignored
    @(posedge clk); #1;
    op = 2'b00; rs1_val = 32'd7; rs2_val = 32'd6; rd_in = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (i == 3 || i == 10) begin
        op = 2'b10; rs1_val = 32'd99; rs2_val = 32'd0; rd_in = 5'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("busy_start_lat", 32'(lat), 32'd33);
    check("busy_start_res", result, 32'd42);
    check("busy_start_rd", 32'(rd_out), 32'd5);
    op = 2'b11; rs1_val = 32'd77; rs2_val = 32'd0; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    watch_no_done(40, extra_done);
    check("no_extra_done", 32'(extra_done), 32'd0);
    check("no_extra_res", result, 32'd42);

    // rd = x0: executes and pulses done, but never writes
    run_op(2'b00, 32'd2, 32'd3, 5'd0, lat);
    check("x0_lat", 32'(lat), 32'd33);
    check("x0_done", 32'(done), 32'd1);
    check("x0_regwrite", 32'(reg_write), 32'd0);
    check("x0_res", result, 32'd6);

    // 6. Reset mid-DIVU aborts with no done, then a fresh MUL works
    @(posedge clk); #1;
    op = 2'b10; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_rd", 32'(rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    watch_no_done(40, extra_done);
    check("abort_no_done", 32'(extra_done), 32'd0);
    run_op(2'b00, 32'd3, 32'd3, 5'd1, lat);
    check("post_rst_lat", 32'(lat), 32'd33);
    check("post_rst_res", result, 32'd9);
    check("post_rst_regwrite", 32'(reg_write), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
